// File: rtl/uhci_op_regs_if.sv
// Byte-wide register bus between the AXI slave bridge and the UHCI operational register bank.
interface uhci_op_regs_if #(parameter int usb_reg_W = 6);
  logic [usb_reg_W-1:0] addr_reg;
  logic [7:0]           data_reg;
  logic                 wr_en_reg;
  logic                 rd_en_reg;
  logic [7:0]           r_data_reg;
  logic                 data_reg_toggle;

  modport master (output addr_reg, data_reg, wr_en_reg, rd_en_reg,
                  input  r_data_reg, data_reg_toggle);
  modport slave  (input  addr_reg, data_reg, wr_en_reg, rd_en_reg,
                  output r_data_reg, data_reg_toggle);
endinterface

// File: rtl/uhci_op_regs.sv
// UHCI operational register bank: byte-wide bridge access, frame counter, frame-list pointer and
// host-controller interrupt, all in the Clk_UHCI domain.
module uhci_op_regs #(
  parameter int         usb_reg_W  = 6,
  parameter logic [7:0] SOFMOD_RST = 8'h40
) (
  input  logic              Clk_UHCI,
  input  logic              Rst_UHCI,
  uhci_op_regs_if.slave     bus,
  input  logic              sof_tick,
  input  logic              set_usbint,
  input  logic              set_usberrint,
  input  logic              set_hse,
  input  logic              set_hcpe,
  input  logic [1:0]        port_ccs,
  output logic              run,
  output logic [31:0]       frame_list_addr,
  output logic              irq
);
  logic [7:0]  a;
  logic [7:0]  d;
  logic        wr;

  logic [7:0]  cmd;       // HCRESET (bit 1) is never stored, so it always reads 0
  logic [4:0]  sts;
  logic        hchalted;
  logic [3:0]  intr;
  logic [10:0] frnum;
  logic [19:0] flbase;
  logic [6:0]  sofmod;
  logic [1:0]  csc, pe, pec;
  logic [1:0]  ccs_prev;

  logic        rd_prev;
  logic [7:0]  rdata;
  logic        hc_reset;
  logic [4:0]  sts_set, sts_w1c;
  logic [1:0]  csc_w1c, pec_w1c;
  logic        irq_next;

  assign a  = 8'(bus.addr_reg);
  assign d  = bus.data_reg;
  assign wr = bus.wr_en_reg;

  assign run             = cmd[0] & ~hchalted;
  assign frame_list_addr = {flbase, frnum[9:0], 2'b00};

  always_comb begin
    rdata = 8'h00;
    case (a)
      8'h00: rdata = cmd;
      8'h02: rdata = {2'b00, hchalted, sts};
      8'h04: rdata = {4'h0, intr};
      8'h06: rdata = frnum[7:0];
      8'h07: rdata = {5'b0, frnum[10:8]};
      8'h09: rdata = {flbase[3:0], 4'h0};
      8'h0A: rdata = flbase[11:4];
      8'h0B: rdata = flbase[19:12];
      8'h0C: rdata = {1'b0, sofmod};
      8'h10: rdata = {4'h0, pec[0], pe[0], csc[0], port_ccs[0]};
      8'h12: rdata = {4'h0, pec[1], pe[1], csc[1], port_ccs[1]};
      default: rdata = 8'h00;
    endcase
  end

  always_comb begin
    hc_reset = wr && (a == 8'h00) && d[1];
    sts_set  = {set_hcpe, set_hse, 1'b0, set_usberrint, set_usbint};
    sts_w1c  = (wr && a == 8'h02) ? d[4:0] : 5'h00;
    csc_w1c  = {wr && a == 8'h12 && d[1], wr && a == 8'h10 && d[1]};
    pec_w1c  = {wr && a == 8'h12 && d[3], wr && a == 8'h10 && d[3]};
    irq_next = (sts[0] & (intr[2] | intr[3])) | (sts[1] & intr[0]) |
               (sts[2] & intr[1]) | sts[3] | sts[4];
  end

  // Read path and connect-status history live outside the HCRESET domain: a host-controller
  // reset neither disturbs the bridge handshake nor fakes a connect change.
  always_ff @(posedge Clk_UHCI) begin
    rd_prev  <= bus.rd_en_reg;
    if (Rst_UHCI) begin
      bus.r_data_reg      <= 8'h00;
      bus.data_reg_toggle <= 1'b0;
      ccs_prev            <= 2'b00;
    end else begin
      ccs_prev <= port_ccs;
      if (bus.rd_en_reg && !rd_prev) begin
        bus.r_data_reg      <= rdata;
        bus.data_reg_toggle <= ~bus.data_reg_toggle;
      end
    end
  end

  always_ff @(posedge Clk_UHCI) begin
    if (Rst_UHCI || hc_reset) begin
      cmd      <= 8'h00;
      sts      <= 5'h00;
      hchalted <= 1'b1;
      intr     <= 4'h0;
      frnum    <= 11'h000;
      flbase   <= 20'h00000;
      sofmod   <= SOFMOD_RST[6:0];
      csc      <= 2'b00;
      pe       <= 2'b00;
      pec      <= 2'b00;
      irq      <= 1'b0;
    end else begin
      hchalted <= ~cmd[0];
      if (wr && a == 8'h00) cmd <= d & 8'hFD;
      // Fatal errors stop the schedule even if software sets RS in the same cycle
      if (set_hse || set_hcpe) cmd[0] <= 1'b0;
      sts <= (sts & ~sts_w1c) | sts_set;
      if (wr && a == 8'h04) intr <= d[3:0];
      if (wr && hchalted && a == 8'h06)      frnum[7:0]  <= d;
      else if (wr && hchalted && a == 8'h07) frnum[10:8] <= d[2:0];
      else if (run && sof_tick)              frnum       <= frnum + 11'd1;
      if (wr && a == 8'h09) flbase[3:0]   <= d[7:4];
      if (wr && a == 8'h0A) flbase[11:4]  <= d;
      if (wr && a == 8'h0B) flbase[19:12] <= d;
      if (wr && a == 8'h0C) sofmod <= d[6:0];
      csc <= (csc & ~csc_w1c) | (port_ccs ^ ccs_prev);
      pec <= pec & ~pec_w1c;
      if (wr && a == 8'h10) pe[0] <= d[2];
      if (wr && a == 8'h12) pe[1] <= d[2];
      irq <= irq_next;
    end
  end
endmodule

// File: tb/tb_uhci_op_regs.sv
// Directed bench for uhci_op_regs: vector table for plain register access plus hand sequences.
module tb_uhci_op_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sof_tick = 1'b0, set_usbint = 1'b0, set_usberrint = 1'b0;
  logic        set_hse = 1'b0, set_hcpe = 1'b0;
  logic [1:0]  port_ccs = 2'b00;
  logic        run, irq;
  logic [31:0] fla;

  uhci_op_regs_if #(.usb_reg_W(6)) bus();

  uhci_op_regs #(.usb_reg_W(6), .SOFMOD_RST(8'h40)) dut (
    .Clk_UHCI(clk), .Rst_UHCI(rst), .bus(bus),
    .sof_tick(sof_tick), .set_usbint(set_usbint), .set_usberrint(set_usberrint),
    .set_hse(set_hse), .set_hcpe(set_hcpe), .port_ccs(port_ccs),
    .run(run), .frame_list_addr(fla), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_wr;
    logic [5:0] addr;
    logic [7:0] data;   // write byte, or expected read byte
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_tog = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.addr_reg = a; bus.data_reg = d; bus.wr_en_reg = 1'b1;
    step();
    bus.wr_en_reg = 1'b0;
  endtask

  task automatic rd_chk(input logic [5:0] a, input logic [7:0] exp, input string nm);
    bus.addr_reg = a; bus.rd_en_reg = 1'b1;
    step();
    bus.rd_en_reg = 1'b0;
    exp_tog = ~exp_tog;
    chk(nm, 32'(bus.r_data_reg), 32'(exp));
    chk({nm, "_tog"}, 32'(bus.data_reg_toggle), 32'(exp_tog));
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr_reg = '0; bus.data_reg = '0; bus.wr_en_reg = 1'b0; bus.rd_en_reg = 1'b0;
    tbl.push_back('{1'b0, 6'h02, 8'h20});
    tbl.push_back('{1'b0, 6'h0C, 8'h40});
    tbl.push_back('{1'b0, 6'h00, 8'h00});
    tbl.push_back('{1'b0, 6'h04, 8'h00});
    tbl.push_back('{1'b1, 6'h08, 8'h00});
    tbl.push_back('{1'b1, 6'h09, 8'h30});
    tbl.push_back('{1'b1, 6'h0A, 8'h12});
    tbl.push_back('{1'b1, 6'h0B, 8'hAB});
    tbl.push_back('{1'b0, 6'h08, 8'h00});
    tbl.push_back('{1'b0, 6'h09, 8'h30});
    tbl.push_back('{1'b0, 6'h0A, 8'h12});
    tbl.push_back('{1'b0, 6'h0B, 8'hAB});
    tbl.push_back('{1'b1, 6'h0E, 8'hFF});
    tbl.push_back('{1'b0, 6'h0E, 8'h00});
    tbl.push_back('{1'b1, 6'h04, 8'hFF});
    tbl.push_back('{1'b0, 6'h04, 8'h0F});
    tbl.push_back('{1'b1, 6'h04, 8'h04});
    tbl.push_back('{1'b0, 6'h05, 8'h00});
    tbl.push_back('{1'b1, 6'h0C, 8'hFF});
    tbl.push_back('{1'b0, 6'h0C, 8'h7F});
    tbl.push_back('{1'b1, 6'h0C, 8'h40});
    tbl.push_back('{1'b1, 6'h06, 8'hFF});
    tbl.push_back('{1'b1, 6'h07, 8'hFF});
    tbl.push_back('{1'b0, 6'h06, 8'hFF});
    tbl.push_back('{1'b0, 6'h07, 8'h07});

    repeat (3) step();
    chk("rst_rdata", 32'(bus.r_data_reg), 32'h0);
    chk("rst_tog", 32'(bus.data_reg_toggle), 32'h0);
    chk("rst_run", 32'(run), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_fla", fla, 32'h0);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else rd_chk(tbl[i].addr, tbl[i].data, $sformatf("vec%0d_rd%02h", i, tbl[i].addr));
    end
    chk("fla_ff", fla, 32'hAB123FFC);

    // Run, then one frame tick wraps FRNUM 7FF -> 000; FRNUM write while running ignored
    wr(6'h00, 8'h01);
    chk("run_lag", 32'(run), 32'h0);
    step();
    chk("run_on", 32'(run), 32'h1);
    sof_tick = 1'b1; step(); sof_tick = 1'b0;
    rd_chk(6'h06, 8'h00, "frnum_wrap_lo");
    rd_chk(6'h07, 8'h00, "frnum_wrap_hi");
    wr(6'h06, 8'h55);
    rd_chk(6'h06, 8'h00, "frnum_locked");
    chk("fla_wrap", fla, 32'hAB123000);

    // Set beats W1C on USBINT; irq follows status by one cycle
    set_usbint = 1'b1;
    wr(6'h02, 8'h01);
    set_usbint = 1'b0;
    rd_chk(6'h02, 8'h01, "usbint_setwins");
    chk("irq_usbint", 32'(irq), 32'h1);
    wr(6'h02, 8'h01);
    chk("irq_lag", 32'(irq), 32'h1);
    step();
    chk("irq_clr", 32'(irq), 32'h0);
    rd_chk(6'h02, 8'h00, "usbint_clr");

    // Host system error stops the controller and interrupts regardless of USBINTR
    wr(6'h04, 8'h00);
    set_hse = 1'b1; step(); set_hse = 1'b0;
    chk("hse_run", 32'(run), 32'h0);
    chk("hse_irq_lag", 32'(irq), 32'h0);
    step();
    chk("hse_irq", 32'(irq), 32'h1);
    rd_chk(6'h02, 8'h28, "hse_sts");
    rd_chk(6'h00, 8'h00, "hse_cmd");
    wr(6'h02, 8'h08);
    step();
    chk("hse_irq_clr", 32'(irq), 32'h0);

    // Read and write in the same cycle: read sees pre-write value
    bus.addr_reg = 6'h04; bus.data_reg = 8'h0A; bus.wr_en_reg = 1'b1; bus.rd_en_reg = 1'b1;
    step();
    bus.wr_en_reg = 1'b0; bus.rd_en_reg = 1'b0;
    exp_tog = ~exp_tog;
    chk("rw_same_old", 32'(bus.r_data_reg), 32'h00);
    chk("rw_same_tog", 32'(bus.data_reg_toggle), 32'(exp_tog));
    step();
    rd_chk(6'h04, 8'h0A, "rw_same_new");

    // Connect change, W1C, port enable, then HCRESET
    port_ccs = 2'b01;
    step();
    rd_chk(6'h10, 8'h03, "portsc1_csc");
    wr(6'h10, 8'h02);
    rd_chk(6'h10, 8'h01, "portsc1_w1c");
    rd_chk(6'h12, 8'h00, "portsc2");
    wr(6'h10, 8'h04);
    rd_chk(6'h10, 8'h05, "portsc1_pe");
    wr(6'h00, 8'h01);
    step();
    rd_chk(6'h02, 8'h00, "sts_running");
    wr(6'h00, 8'h02);
    rd_chk(6'h02, 8'h20, "hcreset_sts");
    rd_chk(6'h00, 8'h00, "hcreset_cmd");
    rd_chk(6'h10, 8'h01, "hcreset_portsc");
    rd_chk(6'h0C, 8'h40, "hcreset_sofmod");
    rd_chk(6'h04, 8'h00, "hcreset_intr");
    chk("hcreset_fla", fla, 32'h0);

    // Reset arriving with a read edge drops the read and clears the toggle
    if (!exp_tog) rd_chk(6'h0C, 8'h40, "pre_rst_rd");
    bus.addr_reg = 6'h0C; bus.rd_en_reg = 1'b1; rst = 1'b1;
    step();
    chk("midrd_tog", 32'(bus.data_reg_toggle), 32'h0);
    chk("midrd_rdata", 32'(bus.r_data_reg), 32'h0);
    rst = 1'b0; bus.rd_en_reg = 1'b0;
    step();
    exp_tog = 1'b0;
    chk("midrd_tog2", 32'(bus.data_reg_toggle), 32'h0);
    chk("midrd_run", 32'(run), 32'h0);
    chk("midrd_irq", 32'(irq), 32'h0);
    rd_chk(6'h0C, 8'h40, "post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
